// File: rtl/lod_norm_sched.sv
// rtl/lod_norm_sched.sv - shared leading-one encoder/normaliser with round-robin arbitration
// Optional feature macro: LOD_SCHED_STATS_EN (adds stat_served / stat_stall counters)
module lod_norm_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 20,
  parameter int POS_W   = 5,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [POS_W-1:0]          rsp_pos,
  output logic [DATA_W-1:0]         rsp_norm,
  output logic                      rsp_zero,
  output logic                      busy
`ifdef LOD_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_served,
  output logic [15:0]               stat_stall
`endif
);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_any;
  int                 idx;

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;
  logic [ID_W-1:0]    s1_id;
  logic               s1_accept;
  logic               s2_load;
  logic               hs;

  logic [POS_W-1:0]   lod_pos;
  logic [POS_W-1:0]   shamt;
  logic [DATA_W-1:0]  lod_norm;

  // Round-robin grant: first valid requester above the pointer, wrapping; independent of ready
  always_comb begin
    grant   = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gnt_id     = idx[ID_W-1:0];
        gnt_any    = 1'b1;
      end
    end
  end

  // Pipeline advance conditions; s2 draining frees s1 in the same edge so no bubble appears
  always_comb begin
    s2_load   = !rsp_valid || rsp_ready;
    s1_accept = !s1_valid || s2_load;
    req_ready = grant & {NUM_REQ{s1_accept}};
    hs        = gnt_any && s1_accept;
  end

  // Pointer moves to the granted requester only when the handshake completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= ID_W'(NUM_REQ - 1);
    end else if (hs) begin
      ptr <= gnt_id;
    end
  end

  // Stage s1 captures the accepted operand and the id of its requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else if (s1_accept) begin
      s1_valid <= hs;
      if (hs) begin
        s1_data <= req_data[gnt_id*DATA_W +: DATA_W];
        s1_id   <= gnt_id;
      end
    end
  end

  // Leading-one position (index+1, 0 for zero) and left-normalising shift of the s1 operand
  always_comb begin
    lod_pos = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (s1_data[i]) lod_pos = POS_W'(i + 1);
    end
    shamt    = POS_W'(DATA_W) - lod_pos;
    lod_norm = (lod_pos == '0) ? '0 : (s1_data << shamt);
  end

  // Stage s2 output registers; hold everything while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_pos   <= '0;
      rsp_norm  <= '0;
      rsp_zero  <= 1'b0;
    end else if (s2_load) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id   <= s1_id;
        rsp_pos  <= lod_pos;
        rsp_norm <= lod_norm;
        rsp_zero <= (lod_pos == '0);
      end
    end
  end

  // Occupancy indicator
  always_comb begin
    busy = s1_valid || rsp_valid;
  end

`ifdef LOD_SCHED_STATS_EN
  // Saturating per-requester accept counters and output stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_served <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && stat_served[i*16 +: 16] != 16'hFFFF) begin
          stat_served[i*16 +: 16] <= stat_served[i*16 +: 16] + 16'd1;
        end
      end
      if (rsp_valid && !rsp_ready && stat_stall != 16'hFFFF) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lod_norm_sched.sv
// tb/tb_lod_norm_sched.sv - scoreboard bench for lod_norm_sched
module tb_lod_norm_sched;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 20;
  localparam int POS_W   = 5;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [POS_W-1:0]  pos;
    logic [DATA_W-1:0] norm;
    logic              zero;
  } rsp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      rsp_valid;
  logic                      rsp_ready = 1'b0;
  logic [ID_W-1:0]           rsp_id;
  logic [POS_W-1:0]          rsp_pos;
  logic [DATA_W-1:0]         rsp_norm;
  logic                      rsp_zero;
  logic                      busy;

  int   checks = 0;
  int   failures = 0;
  rsp_t sb_q[$];
  rsp_t exp_r;
  rsp_t got_r;
  logic allow_drop = 1'b1;
  logic [NUM_REQ-1:0] prev_pend = '0;

  logic [DATA_W-1:0] bd_data[3] = '{20'h00000, 20'h80000, 20'h00001};
  logic [POS_W-1:0]  bd_pos[3]  = '{5'd0, 5'd20, 5'd1};
  logic [DATA_W-1:0] bd_norm[3] = '{20'h00000, 20'h80000, 20'h80000};
  logic              bd_zero[3] = '{1'b1, 1'b0, 1'b0};

  lod_norm_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .POS_W(POS_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_pos(rsp_pos),
    .rsp_norm(rsp_norm), .rsp_zero(rsp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: shift left until the MSB is set, counting down from DATA_W
  function automatic rsp_t model(input logic [DATA_W-1:0] d, input int id);
    rsp_t r;
    logic [DATA_W-1:0] t;
    r.id   = ID_W'(id);
    r.zero = (d == '0);
    r.pos  = '0;
    r.norm = '0;
    if (d != '0) begin
      t = d;
      r.pos = POS_W'(DATA_W);
      while (!t[DATA_W-1]) begin
        t = t << 1;
        r.pos = r.pos - 1'b1;
      end
      r.norm = t;
    end
    return r;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted request, pop and compare on consumed response
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_pend = '0;
    end else begin
      checks++;
      if ($countones(req_ready) > 1) begin
        failures++;
        $display("FAIL onehot_ready got=%b exp=at_most_one_bit", req_ready);
      end
      checks++;
      if (((prev_pend & ~req_valid) != '0) && !allow_drop) begin
        failures++;
        $display("FAIL valid_drop got=%b exp=held_pending=%b", req_valid, prev_pend);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) sb_q.push_back(model(req_data[i*DATA_W +: DATA_W], i));
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        got_r = {rsp_id, rsp_pos, rsp_norm, rsp_zero};
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got=%h exp=no_response", got_r);
        end else begin
          exp_r = sb_q.pop_front();
          if (got_r !== exp_r) begin
            failures++;
            $display("FAIL sb_rsp got=id%0d pos%0d norm%h z%b exp=id%0d pos%0d norm%h z%b",
                     got_r.id, got_r.pos, got_r.norm, got_r.zero,
                     exp_r.id, exp_r.pos, exp_r.norm, exp_r.zero);
          end
        end
      end
      prev_pend = req_valid & ~req_ready;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=busy%b pending%0d exp=busy0 pending0", busy, sb_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({rsp_valid, busy, rsp_zero} !== 3'b000 || rsp_id !== '0 || rsp_pos !== '0 || rsp_norm !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=v%b b%b id%0d pos%0d norm%h z%b exp=all_zero",
               rsp_valid, busy, rsp_id, rsp_pos, rsp_norm, rsp_zero);
    end
    rst = 1'b0;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_priority got=%b exp=0001", req_ready);
    end
    req_valid = '0;
    tick();
    allow_drop = 1'b0;
  endtask

  task automatic test_single();
    req_data = '0;
    req_data[1*DATA_W +: DATA_W] = 20'h00400;
    req_valid = 4'b0010;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_ready got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_pos !== 5'd11 || rsp_norm !== 20'h80000 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp got=v%b id%0d pos%0d norm%h z%b exp=v1 id1 pos11 norm80000 z0",
               rsp_valid, rsp_id, rsp_pos, rsp_norm, rsp_zero);
    end
    tick();
  endtask

  task automatic test_boundaries();
    for (int j = 0; j < 3; j++) begin
      req_data[0 +: DATA_W] = bd_data[j];
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_pos !== bd_pos[j] || rsp_norm !== bd_norm[j] || rsp_zero !== bd_zero[j]) begin
        failures++;
        $display("FAIL boundary_%0d got=v%b id%0d pos%0d norm%h z%b exp=v1 id0 pos%0d norm%h z%b",
                 j, rsp_valid, rsp_id, rsp_pos, rsp_norm, rsp_zero, bd_pos[j], bd_norm[j], bd_zero[j]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int g[16];
    int expg;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom) >> $urandom_range(0, DATA_W);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int c = 0; c < 16; c++) begin
      g[c] = -1;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) g[c] = i;
      expg = (c == 0) ? 1 : (g[c-1] + 1) % NUM_REQ;
      checks++;
      if (g[c] != expg) begin
        failures++;
        $display("FAIL b2b_grant c%0d got=%0d exp=%0d", c, g[c], expg);
      end
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || int'(rsp_id) != g[c-2]) begin
          failures++;
          $display("FAIL b2b_rsp_id c%0d got=v%b id%0d exp=v1 id%0d", c, rsp_valid, rsp_id, g[c-2]);
        end
      end
      tick();
      if (g[c] >= 0) req_data[g[c]*DATA_W +: DATA_W] = DATA_W'($urandom) >> $urandom_range(0, DATA_W);
      #1;
    end
  endtask

  task automatic test_backpressure();
    rsp_t snap;
    int accepted;
    accepted = 0;
    rsp_ready = 1'b0;
    #1;
    snap = {rsp_id, rsp_pos, rsp_norm, rsp_zero};
    for (int c = 0; c < 3; c++) begin
      accepted += $countones(req_valid & req_ready);
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_id, rsp_pos, rsp_norm, rsp_zero} !== snap) begin
        failures++;
        $display("FAIL bp_frozen c%0d got=v%b %h exp=v1 %h", c, rsp_valid, {rsp_id, rsp_pos, rsp_norm, rsp_zero}, snap);
      end
      tick();
    end
    checks++;
    if (accepted > 2 || req_ready !== '0) begin
      failures++;
      $display("FAIL bp_occupancy got=acc%0d ready%b exp=acc<=2 ready0000", accepted, req_ready);
    end
    allow_drop = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();
    allow_drop = 1'b0;
  endtask

  task automatic test_pointer();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL ptr_fill got=%b exp=0100", req_ready);
    end
    tick();
    req_valid = 4'b1100;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL ptr_full got=%b exp=0000", req_ready);
    end
    tick();
    allow_drop = 1'b1;
    req_valid = 4'b0100;
    tick();
    allow_drop = 1'b0;
    req_valid = 4'b1100;
    tick();
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL ptr_first got=%b exp=1000", req_ready);
    end
    tick();
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL ptr_second got=%b exp=0100", req_ready);
    end
    tick();
    req_valid = '0;
    drain();
  endtask

  task automatic test_reset_inflight();
    rsp_ready = 1'b0;
    req_data[0 +: DATA_W] = DATA_W'($urandom);
    req_valid = 4'b0001;
    tick();
    req_data[0 +: DATA_W] = DATA_W'($urandom);
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_fill got=v%b b%b exp=v1 b1", rsp_valid, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got=v%b b%b exp=v0 b0", rsp_valid, busy);
    end
    tick(2);
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_data[0 +: DATA_W] = 20'h00010;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rst_rearm got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_pos !== 5'd5 || rsp_norm !== 20'h80000 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL rst_after got=v%b id%0d pos%0d norm%h z%b exp=v1 id0 pos5 norm80000 z0",
               rsp_valid, rsp_id, rsp_pos, rsp_norm, rsp_zero);
    end
    drain();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_boundaries();
    test_back_to_back();
    test_backpressure();
    test_pointer();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
